// File: rtl/seg_scan_if.sv
// Bus between the BCD converter side and the seven-segment scanner:
// captured value/strobe in, segment and anode drives out.
interface seg_scan_if;
  logic [19:0] dec;
  logic        neg;
  logic        upd;
  logic [7:0]  seg;
  logic [5:0]  an;

  modport master (output dec, output neg, output upd, input seg, input an);
  modport slave  (input dec, input neg, input upd, output seg, output an);
endinterface

// File: rtl/seg_scan.sv
// Six-position multiplexed seven-segment driver: shadow/display double buffer,
// leading-zero blanking, sign position and error glyph for non-decimal nibbles.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_SIGN  = 3'd5;

  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_ERROR = 8'h86;

  logic [PW-1:0] pcnt_q,   pcnt_d;
  logic [2:0]    idx_q,    idx_d;
  logic [19:0]   sh_dec_q, sh_dec_d;
  logic          sh_neg_q, sh_neg_d;
  logic [19:0]   ds_dec_q, ds_dec_d;
  logic          ds_neg_q, ds_neg_d;
  logic [7:0]    seg_q,    seg_d;
  logic [5:0]    an_q,     an_d;

  logic [4:0] nz;
  logic [4:0] shown;
  logic [3:0] nib;

  function automatic logic [7:0] digit_glyph(input logic [3:0] n);
    case (n)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return GLYPH_ERROR;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    sh_dec_d = sh_dec_q;
    sh_neg_d = sh_neg_q;
    ds_dec_d = ds_dec_q;
    ds_neg_d = ds_neg_q;

    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      if (idx_q == IDX_SIGN) begin
        // Frame boundary: display takes the pre-edge shadow, so an upd on
        // this same edge only shows from the following frame.
        idx_d    = 3'd0;
        ds_dec_d = sh_dec_q;
        ds_neg_d = sh_neg_q;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end

    if (bus.upd) begin
      sh_dec_d = bus.dec;
      sh_neg_d = bus.neg;
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) nz[k] = |ds_dec_q[4*k +: 4];
    // A position is shown if it or any more-significant nibble is nonzero;
    // units are always shown.
    shown[4] = nz[4];
    for (int k = 3; k >= 1; k--) shown[k] = shown[k+1] | nz[k];
    shown[0] = 1'b1;

    case (idx_q)
      3'd0:    nib = ds_dec_q[3:0];
      3'd1:    nib = ds_dec_q[7:4];
      3'd2:    nib = ds_dec_q[11:8];
      3'd3:    nib = ds_dec_q[15:12];
      3'd4:    nib = ds_dec_q[19:16];
      default: nib = 4'd0;
    endcase

    seg_d = GLYPH_BLANK;
    if (idx_q == IDX_SIGN) begin
      if (ds_neg_q && (ds_dec_q != '0)) seg_d = GLYPH_MINUS;
    end else if (idx_q < IDX_SIGN) begin
      if (shown[idx_q]) seg_d = digit_glyph(nib);
    end

    an_d = ~(6'd1 << idx_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      idx_q    <= 3'd0;
      sh_dec_q <= '0;
      sh_neg_q <= 1'b0;
      ds_dec_q <= '0;
      ds_neg_q <= 1'b0;
      seg_q    <= GLYPH_BLANK;
      an_q     <= 6'h3F;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      sh_dec_q <= sh_dec_d;
      sh_neg_q <= sh_neg_d;
      ds_dec_q <= ds_dec_d;
      ds_neg_q <= ds_neg_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed 6-position seven-segment display driver directly downstream of the BCD converter in the calculator datapath. Captures the converter's 20-bit packed BCD magnitude plus a sign flag on an update strobe, double-buffers it so the display never tears mid-frame, and time-multiplexes five decimal digits and one sign position. Applies leading-zero blanking and an error glyph for non-decimal nibbles.

## Interface
- SCAN_DIV, default 50000: clock cycles each digit position stays lit; legal range 2..2^20.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- dec  in  20  packed BCD magnitude; [3:0] units … [19:16] ten-thousands.
- neg  in  1  sign of the value; 1 = negative. Delayed upstream to align with dec.
- upd  in  1  capture strobe; dec/neg sampled on any edge where upd=1.
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp (bit 7) always 1.
- an   out  6  active-low position enables; an[0]=units … an[4]=ten-thousands, an[5]=sign.

## Operation
- Shadow registers sh_dec/sh_neg load dec/neg on every edge with upd=1; otherwise hold.
- Display registers ds_dec/ds_neg load from the shadow only at a frame boundary (see Timing). upd coincident with a frame boundary: display takes the pre-edge shadow; new value shows from the following frame.
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps; index idx (0..5) advances on pcnt==SCAN_DIV-1, wrapping 5→0.
- Leading-zero blanking on ds_dec: position k (1..4) is blank if nibbles k..4 are all zero. Position 0 always shown.
- Sign position 5: minus (8'hBF) when ds_neg=1 and ds_dec≠0; else blank. Negative zero shows "0" only.
- Glyphs (seg): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, minus=BF, blank=FF, error=86 ("E").
- Any nibble A..F at a non-blanked position shows error glyph. A nonzero A..F nibble counts as nonzero for blanking.
- an: exactly one bit low (bit idx) outside reset, including blanked positions; seg=FF there.

## Timing
- Reset (rst=1 at an edge): pcnt=0, idx=0, sh_dec=0, sh_neg=0, ds_dec=0, ds_neg=0, seg=8'hFF, an=6'h3F. Holds while rst=1; reset mid-frame discards shadow and display contents.
- seg/an are registered: they reflect idx and ds_* as of the previous edge (1-cycle latency from idx change).
- First edge after rst deasserts: seg=C0, an=6'b111110.
- Frame boundary: edge where pcnt==SCAN_DIV-1 and idx==5; same edge sets idx=0, pcnt=0 and loads ds_* from sh_*. First digit of new value appears on seg one edge later.
- upd-to-display latency: ≤ 6·SCAN_DIV+1 cycles; the whole frame shows one consistent value.
- Each position lit for exactly SCAN_DIV consecutive cycles; frame period 6·SCAN_DIV.
- upd held high continuously: shadow tracks input every cycle; display still changes only at frame boundaries.

## Test plan
- SCAN_DIV=4, reset then idle: seg=FF/an=3F during reset; afterwards an cycles 3E,3D,3B,37,2F,1F every 4 cycles; seg=C0 at an=3E, FF elsewhere.
- upd with dec=20'h12345, neg=0 -> after next frame boundary seg sequence 92,99,B0,A4,F9,FF for an 3E..1F.
- dec=20'h00307, neg=1 -> units F8, tens C0, hundreds B0, thousands FF, ten-thousands FF, sign BF.
- dec=0, neg=1 -> only units C0; sign position FF.
- dec=20'h0000C -> units 86; pulse upd mid-frame with 20'h00009 -> current frame finishes with 86, next frame shows 90.
- Assert rst for 1 cycle mid-frame while displaying 12345 -> next edge seg=FF, an=3F; after release display shows 0 and new upd value appears only after following frame boundary.
